// File: rtl/hilo_pkg.sv
// Shared encodings, FSM states and negation helpers for the HI/LO multiply/divide sequencer.
// The optional divide datapath is enabled with the HILO_DIV_EN macro in the files that use it.
package hilo_pkg;

    localparam int ITER_DEF = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_NOP6  = 3'b110,
        OP_NOP7  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FIX   = 3'd3,
        ST_WRITE = 3'd4
    } state_e;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of shift-add multiply or restoring divide on a {hi,lo} accumulator.
// The trial-subtract path exists only when HILO_DIV_EN is defined.
module muldiv_step
    import hilo_pkg::*;
(
    input  logic        div_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] opnd_i,
    input  logic        bit_i,
    output logic [63:0] acc_o
);

    logic [32:0] sum_s;

`ifdef HILO_DIV_EN
    logic [32:0] rem_sh_s;
    logic [33:0] trial_s;

    // Multiply: add then shift right with carry. Divide: shift in dividend bit, trial subtract.
    always_comb begin
        sum_s    = {1'b0, acc_i[63:32]} + (bit_i ? {1'b0, opnd_i} : 33'd0);
        rem_sh_s = {acc_i[63:32], bit_i};
        trial_s  = {1'b0, rem_sh_s} - {2'b00, opnd_i};
        if (div_i) begin
            // The shifted remainder can need 33 bits when the divisor exceeds 2^31.
            if (!trial_s[33]) begin
                acc_o = {trial_s[31:0], acc_i[30:0], 1'b1};
            end else begin
                acc_o = {rem_sh_s[31:0], acc_i[30:0], 1'b0};
            end
        end else begin
            acc_o = {sum_s, acc_i[31:1]};
        end
    end
`else
    logic unused_s;

    // Multiply only: add then shift right with carry.
    always_comb begin
        sum_s    = {1'b0, acc_i[63:32]} + (bit_i ? {1'b0, opnd_i} : 33'd0);
        acc_o    = {sum_s, acc_i[31:1]};
        unused_s = div_i ^ acc_i[0];
    end
`endif

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MIPS HI/LO multiply/divide sequencer with registered load strobes and Busy.
// Define HILO_DIV_EN for DIV/DIVU; otherwise divides finish early with HI = LO = 0.
module hilo_muldiv_ctrl
    import hilo_pkg::*;
#(
    parameter int ITER = ITER_DEF
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic        HiLd,
    output logic        LoLd,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        DivZero
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    state_e        state_q, state_d;
    op_e           op_q, op_d, req_op_s;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [63:0]   acc_q, acc_d, step_acc_s, fixed_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pneg_q, pneg_d, rneg_q, rneg_d;
    logic          busy_q, busy_d, done_q, done_d, hild_q, hild_d, lold_q, lold_d, dz_q, dz_d;
    logic [31:0]   hiout_q, hiout_d, loout_q, loout_d;
    logic          is_div_s, is_signed_s, req_md_s, req_mt_s;

    assign req_op_s = op_e'(Op);

    // Decode of the latched and requested operation.
    always_comb begin
        is_div_s    = (op_q == OP_DIV) || (op_q == OP_DIVU);
        is_signed_s = (op_q == OP_MULT) || (op_q == OP_DIV);
        req_md_s    = Start && !Op[2];
        req_mt_s    = Start && ((req_op_s == OP_MTHI) || (req_op_s == OP_MTLO));
    end

    muldiv_step u_step (
        .div_i  (is_div_s),
        .acc_i  (acc_q),
        .opnd_i (is_div_s ? b_q : a_q),
        .bit_i  (is_div_s ? a_q[31] : b_q[0]),
        .acc_o  (step_acc_s)
    );

    // Sign fix-up of the magnitude result.
    always_comb begin
`ifdef HILO_DIV_EN
        if (is_div_s) begin
            fixed_s = {rneg_q ? neg32(acc_q[63:32]) : acc_q[63:32],
                       pneg_q ? neg32(acc_q[31:0])  : acc_q[31:0]};
        end else begin
            fixed_s = pneg_q ? neg64(acc_q) : acc_q;
        end
`else
        fixed_s = pneg_q ? neg64(acc_q) : acc_q;
`endif
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Clr) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_md_s)      state_d = ST_PREP;
                else if (req_mt_s) state_d = ST_WRITE;
                else               state_d = ST_IDLE;
            end
`ifdef HILO_DIV_EN
            ST_PREP: state_d = (is_div_s && (b_q == 32'h0)) ? ST_WRITE : ST_RUN;
`else
            ST_PREP: state_d = is_div_s ? ST_WRITE : ST_RUN;
`endif
            ST_RUN:   state_d = (cnt_q == CNT_LAST) ? ST_FIX : ST_RUN;
            ST_FIX:   state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Operand, accumulator and counter updates.
    always_comb begin
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        pneg_d = pneg_q;
        rneg_d = rneg_q;
        case (state_q)
            ST_IDLE: begin
                if (req_md_s || req_mt_s) begin
                    op_d = req_op_s;
                    a_d  = A;
                    b_d  = B;
                end else begin
                    op_d = op_q;
                end
            end
            ST_PREP: begin
                a_d    = (is_signed_s && a_q[31]) ? neg32(a_q) : a_q;
                b_d    = (is_signed_s && b_q[31]) ? neg32(b_q) : b_q;
                pneg_d = is_signed_s && (a_q[31] ^ b_q[31]);
                rneg_d = is_signed_s && a_q[31];
                acc_d  = 64'h0;
                cnt_d  = '0;
            end
            ST_RUN: begin
                acc_d = step_acc_s;
                cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);
                if (is_div_s) a_d = {a_q[30:0], 1'b0};
                else          b_d = {1'b0, b_q[31:1]};
            end
            ST_FIX:  acc_d = fixed_s;
            default: acc_d = acc_q;
        endcase
    end

    // Output values, loaded on the edge that enters WRITE so they are visible in WRITE.
    always_comb begin
        done_d  = (state_d == ST_WRITE);
        busy_d  = (state_d == ST_PREP) || (state_d == ST_RUN) || (state_d == ST_FIX) ||
                  ((state_d == ST_WRITE) && (state_q != ST_IDLE));
        hild_d  = 1'b0;
        lold_d  = 1'b0;
        dz_d    = 1'b0;
        hiout_d = hiout_q;
        loout_d = loout_q;
        case (state_q)
            ST_IDLE: begin
                if (req_mt_s && (req_op_s == OP_MTHI)) begin
                    hild_d  = 1'b1;
                    hiout_d = A;
                end else if (req_mt_s) begin
                    lold_d  = 1'b1;
                    loout_d = A;
                end else begin
                    hild_d = 1'b0;
                end
            end
            ST_PREP: begin
                if (state_d == ST_WRITE) begin
                    hild_d  = 1'b1;
                    lold_d  = 1'b1;
`ifdef HILO_DIV_EN
                    hiout_d = a_q;
                    loout_d = 32'hFFFF_FFFF;
                    dz_d    = 1'b1;
`else
                    hiout_d = 32'h0;
                    loout_d = 32'h0;
`endif
                end else begin
                    hild_d = 1'b0;
                end
            end
            ST_FIX: begin
                hild_d  = 1'b1;
                lold_d  = 1'b1;
                hiout_d = fixed_s[63:32];
                loout_d = fixed_s[31:0];
            end
            default: hild_d = 1'b0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            op_q    <= OP_MULT;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            acc_q   <= 64'h0;
            cnt_q   <= '0;
            pneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hild_q  <= 1'b0;
            lold_q  <= 1'b0;
            dz_q    <= 1'b0;
            hiout_q <= 32'h0;
            loout_q <= 32'h0;
        end else begin
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            pneg_q  <= pneg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hild_q  <= hild_d;
            lold_q  <= lold_d;
            dz_q    <= dz_d;
            hiout_q <= hiout_d;
            loout_q <= loout_d;
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign HiLd    = hild_q;
    assign LoLd    = lold_q;
    assign HiOut   = hiout_q;
    assign LoOut   = loout_q;
    assign DivZero = dz_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl; divide expectations follow whether HILO_DIV_EN is defined.
module tb_hilo_muldiv_ctrl;

    logic        Clk = 1'b0;
    logic        Clr, Start;
    logic [2:0]  Op;
    logic [31:0] A, B;
    logic        Busy, Done, HiLd, LoLd, DivZero;
    logic [31:0] HiOut, LoOut;

    int tests = 0;
    int fails = 0;

    hilo_muldiv_ctrl dut (
        .Clk(Clk), .Clr(Clr), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .HiLd(HiLd), .LoLd(LoLd),
        .HiOut(HiOut), .LoOut(LoOut), .DivZero(DivZero)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Issues one request in the current cycle (cycle 0) and captures what appears in the Done cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int wcyc, output int nbusy, output logic [31:0] hi,
                          output logic [31:0] lo, output logic [2:0] strb, output logic [4:0] post);
        wcyc = -1; nbusy = 0; hi = 32'h0; lo = 32'h0; strb = 3'b000; post = 5'h1F;
        Start = 1'b1; Op = op; A = a; B = b;
        tick();
        Start = 1'b0; A = 32'hDEAD_BEEF; B = 32'hCAFE_F00D;
        for (int c = 1; c <= 60; c++) begin
            if (Busy) nbusy++;
            if (Done) begin
                wcyc = c; hi = HiOut; lo = LoOut; strb = {HiLd, LoLd, DivZero};
                break;
            end
            tick();
        end
        tick();
        post = {Busy, Done, HiLd, LoLd, DivZero};
    endtask

    task automatic test_reset;
        Clr = 1'b1; Start = 1'b0; Op = 3'b000; A = 32'h0; B = 32'h0;
        tick(); tick();
        Clr = 1'b0;
        tests++;
        if ({Busy, Done, HiLd, LoLd, DivZero, HiOut, LoOut} !== 69'h0) begin
            fails++;
            $display("FAIL reset got ctl=%b hi=%h lo=%h want all zero",
                     {Busy, Done, HiLd, LoLd, DivZero}, HiOut, LoOut);
        end
    endtask

    task automatic test_mul(input string nm, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] prod);
        int w, nb; logic [31:0] hi, lo; logic [2:0] s; logic [4:0] p;
        run_op(op, a, b, w, nb, hi, lo, s, p);
        tests++;
        if (w !== 35 || nb !== 35 || s !== 3'b110) begin
            fails++;
            $display("FAIL %s_ctl got wcyc=%0d busy=%0d hl/ll/dz=%b want 35 35 110", nm, w, nb, s);
        end
        tests++;
        if ({hi, lo} !== prod) begin
            fails++;
            $display("FAIL %s_data got %h_%h want %h", nm, hi, lo, prod);
        end
        tests++;
        if (p !== 5'b0) begin
            fails++;
            $display("FAIL %s_post got %b want 00000", nm, p);
        end
    endtask

    // Divide: expected values depend on whether the divide datapath is built.
    task automatic test_div(input string nm, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int w, nb, ew; logic [31:0] hi, lo, xhi, xlo; logic [2:0] s, es; logic [4:0] p;
`ifdef HILO_DIV_EN
        ew = (b == 32'h0) ? 2 : 35;
        es = (b == 32'h0) ? 3'b111 : 3'b110;
        xhi = ehi; xlo = elo;
`else
        ew = 2; es = 3'b110; xhi = 32'h0; xlo = 32'h0;
`endif
        run_op(op, a, b, w, nb, hi, lo, s, p);
        tests++;
        if (w !== ew || nb !== ew || s !== es) begin
            fails++;
            $display("FAIL %s_ctl got wcyc=%0d busy=%0d hl/ll/dz=%b want %0d %0d %b",
                     nm, w, nb, s, ew, ew, es);
        end
        tests++;
        if (hi !== xhi || lo !== xlo) begin
            fails++;
            $display("FAIL %s_data got hi=%h lo=%h want hi=%h lo=%h", nm, hi, lo, xhi, xlo);
        end
        tests++;
        if (p !== 5'b0) begin
            fails++;
            $display("FAIL %s_post got %b want 00000", nm, p);
        end
    endtask

    task automatic test_mt_back_to_back;
        logic seen_busy;
        seen_busy = 1'b0;
        Start = 1'b1; Op = 3'b100; A = 32'h1234_5678;
        tick();
        Start = 1'b0; A = 32'h0;
        seen_busy |= Busy;
        tests++;
        if ({Done, HiLd, LoLd} !== 3'b110 || HiOut !== 32'h1234_5678) begin
            fails++;
            $display("FAIL mthi_c1 got d/hl/ll=%b hi=%h want 110 12345678", {Done, HiLd, LoLd}, HiOut);
        end
        tick();
        seen_busy |= Busy;
        tests++;
        if ({Done, HiLd, LoLd} !== 3'b000) begin
            fails++;
            $display("FAIL mt_c2 got d/hl/ll=%b want 000", {Done, HiLd, LoLd});
        end
        Start = 1'b1; Op = 3'b101; A = 32'h9ABC_DEF0;
        tick();
        Start = 1'b0; A = 32'h0;
        seen_busy |= Busy;
        tests++;
        if ({Done, HiLd, LoLd} !== 3'b101 || LoOut !== 32'h9ABC_DEF0) begin
            fails++;
            $display("FAIL mtlo_c3 got d/hl/ll=%b lo=%h want 101 9abcdef0", {Done, HiLd, LoLd}, LoOut);
        end
        tick();
        seen_busy |= Busy;
        tests++;
        if (seen_busy !== 1'b0 || {Done, LoLd} !== 2'b00) begin
            fails++;
            $display("FAIL mt_busy got busy_seen=%b d/ll=%b want 0 00", seen_busy, {Done, LoLd});
        end
    endtask

    task automatic test_nop;
        logic any;
        any = 1'b0;
        Start = 1'b1; Op = 3'b110; A = 32'h5555_5555;
        tick();
        Op = 3'b111;
        any |= Busy | Done | HiLd | LoLd;
        tick();
        Start = 1'b0;
        any |= Busy | Done | HiLd | LoLd;
        tick();
        any |= Busy | Done | HiLd | LoLd;
        tests++;
        if (any !== 1'b0) begin
            fails++;
            $display("FAIL nop got activity=%b want 0", any);
        end
    endtask

    task automatic test_clr_abort;
        logic strobe_seen;
        int w, nb; logic [31:0] hi, lo; logic [2:0] s; logic [4:0] p;
        strobe_seen = 1'b0;
        Start = 1'b1; Op = 3'b000; A = 32'd3; B = 32'd5;
        tick();
        Start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            strobe_seen |= Done | HiLd | LoLd;
            tick();
        end
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        strobe_seen |= Done | HiLd | LoLd;
        tests++;
        if (Busy !== 1'b0 || strobe_seen !== 1'b0) begin
            fails++;
            $display("FAIL clr_c11 got busy=%b strobe_seen=%b want 0 0", Busy, strobe_seen);
        end
        tick();
        run_op(3'b000, 32'hFFFF_FFFE, 32'h4000_0000, w, nb, hi, lo, s, p);
        tests++;
        if (12 + w !== 47 || {hi, lo} !== 64'hFFFF_FFFF_8000_0000 || s !== 3'b110) begin
            fails++;
            $display("FAIL clr_restart got wcyc=%0d data=%h_%h strb=%b want 47 ffffffff_80000000 110",
                     12 + w, hi, lo, s);
        end
    endtask

    initial begin
        test_reset();
        test_mul("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        test_mul("mult_neg",  3'b000, 32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB);
        test_mul("mult_pos",  3'b000, 32'h0001_0000, 32'h0001_0003, 64'h0000_0001_0003_0000);
        test_div("div_neg",   3'b010, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        test_div("div_negb",  3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD);
        test_div("divu",      3'b011, 32'd100,       32'd7,        32'd2,         32'd14);
        test_div("divu_big",  3'b011, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'd1);
        test_div("div_zero",  3'b010, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF);
        test_div("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);
        test_mt_back_to_back();
        test_nop();
        test_clr_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer that produces the values for the HI and LO registers of the MIPS datapath. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the ID/EX stage. It runs a 32-iteration shift-add multiply or restoring divide, then pulses load strobes and data to the external HI/LO registers. It drives `Busy` so the hazard unit stalls MFHI/MFLO and new HI/LO requests until the result is written.

## Interface
- `ITER`, 32: iterations per multiply/divide; equals operand width.
- `Clk`  in  1  rising-edge clock.
- `Clr`  in  1  synchronous, active-high reset.
- `Start`  in  1  request valid. Sampled only while `Busy`=0.
- `Op`  in  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110/111: no-op.
- `A`  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `B`  in  32  rt operand: multiplier or divisor.
- `Busy`  out  1  high from the cycle after an accepted mul/div `Start` through its write cycle.
- `Done`  out  1  one-cycle pulse in the write cycle.
- `HiLd`  out  1  one-cycle load strobe to the HI register.
- `LoLd`  out  1  one-cycle load strobe to the LO register.
- `HiOut`  out  32  HI write data. Valid while `HiLd`=1.
- `LoOut`  out  32  LO write data. Valid while `LoLd`=1.
- `DivZero`  out  1  pulses with `Done` when a DIV/DIVU had `B`=0.

## Operation
- States:
  - IDLE → PREP → RUN → FIX → WRITE → IDLE.
  - MTHI/MTLO go IDLE → WRITE → IDLE.
  - Divide-by-zero goes PREP → WRITE.
- IDLE:
  - `Start`=1 with a mul/div `Op` latches `Op`, `A`, `B`, then goes to PREP.
  - MTHI/MTLO latch `A`, then go to WRITE. `Busy` stays 0 for MTHI/MTLO.
  - `Op` 110/111: request ignored.
- PREP:
  - Signed ops replace operands with their magnitudes and record the result signs:
    - product sign = sign(A) xor sign(B);
    - quotient sign = sign(A) xor sign(B);
    - remainder sign = sign(A).
  - Clears the 64-bit accumulator and the iteration counter.
- RUN: exactly `ITER` cycles. Counter runs 0..ITER-1 with no wrap past ITER-1.
  - Multiply: if the multiplier LSB is set, add the multiplicand into the upper half. Shift right 1 with carry (65-bit intermediate).
  - Divide: shift remainder:quotient left 1 and trial-subtract the divisor. If non-negative, keep the result and set the quotient LSB.
- FIX: apply the recorded signs using two's-complement negation.
  - Multiply: negate the 64-bit product.
  - Divide: negate quotient and remainder separately.
- WRITE: drive data and assert `Done`, then go to IDLE.
  - MULT/MULTU: HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
  - MTHI: `HiLd` only. MTLO: `LoLd` only. `Done` pulses for these too.
- Divide by zero: HI = A, LO = 0xFFFFFFFF, `DivZero`=1.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of magnitude arithmetic; no special case.
- `Start` while `Busy`=1 is ignored. The stall logic must not issue it.

## Timing
- Reset values: state IDLE; `Busy`, `Done`, `HiLd`, `LoLd`, `DivZero` = 0; `HiOut`, `LoOut`, accumulator = 0.
- `Clr` mid-operation aborts in the next cycle. No strobe is emitted.
- Mul/div, with `Start` sampled at cycle 0:
  - PREP at cycle 1;
  - RUN at cycles 2..33;
  - FIX at cycle 34;
  - WRITE at cycle 35.
  - `Busy`=1 for cycles 1..35. A new `Start` can be accepted at cycle 36.
- Divide by zero: WRITE at cycle 2, `Busy`=1 for cycles 1..2.
- MTHI/MTLO: WRITE at cycle 1. A back-to-back `Start` is accepted at cycle 2.
- All outputs are registered.

## Configuration
- `HILO_DIV_EN` defined: full DIV/DIVU support as above.
- `HILO_DIV_EN` undefined:
  - divide datapath removed;
  - DIV/DIVU go PREP → WRITE with HI = LO = 0;
  - `DivZero` is tied to 0.

## Structure
- `hilo_pkg`:
  - `Op` encodings;
  - state enum (IDLE, PREP, RUN, FIX, WRITE);
  - `ITER` default.
- Sub-module `muldiv_step`: combinational single-iteration datapath, covering the add-shift and the trial subtract. The controller instantiates it once and owns all registers and the FSM.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → cycle 35: HI=0xFFFFFFFE, LO=0x00000001; `HiLd`=`LoLd`=`Done`=1; `Busy` high cycles 1..35.
- MULT A=0xFFFFFFFD (-3), B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV A=-7, B=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=100, B=7 → LO=14, HI=2.
- DIV A=5, B=0 → cycle 2: HI=5, LO=0xFFFFFFFF, `DivZero`=1. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 at cycle 2 → `HiLd` only at cycle 1, `LoLd` only at cycle 3; `Busy` never asserted.
- `Clr` at cycle 10 of a MULT → no `Done`, `HiLd` or `LoLd`; `Busy`=0 from cycle 11. A `Start` at cycle 12 completes normally at cycle 47.
